i2c_cfg_sequencer: RTL and testbench
====================================

Name: i2c_cfg_sequencer

Overview:
Parametrised sequencer that walks an external sensor-configuration LUT of {register address, register data} entries and issues one I2C register write per entry through a request/acknowledge handshake to the I2C master.
- Entries with an all-zero address are delay tokens: no bus traffic, only a programmable wait.
- Register address width and data width are generic (8/16-bit sensors).
- NACKs are retried a bounded number of times.
- Sits between the per-sensor config LUT modules and the I2C bit-level master; drives the sensor bring-up flag used by the video pipeline.

Parameters:
ADDR_W, 16, register address width in bits (8 or 16)
DATA_W, 16, register data width in bits (8 or 16)
IDX_W, 8, LUT index / size width
DELAY_CYC, 20'd200000, clk cycles waited per delay token
DELAY_W, 20, width of the delay counter
MAX_RETRY, 3, re-issues allowed per entry after a NACK

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a sequence when idle
lut_index  out  IDX_W  current LUT index
lut_data  in  ADDR_W+DATA_W  {addr, data}, combinational from LUT
lut_size  in  IDX_W  number of entries
i2c_req  out  1  transaction request, held until i2c_ack or i2c_nack
i2c_rd  out  1  1 = read transaction (ID check only)
i2c_addr  out  ADDR_W  register address
i2c_wdata  out  DATA_W  write data
i2c_rdata  in  DATA_W  read data, valid with i2c_ack
i2c_ack  in  1  one-cycle completion pulse
i2c_nack  in  1  one-cycle slave-NACK pulse
busy  out  1  sequence in progress
cfg_done  out  1  sticky: all entries completed
cfg_error  out  1  sticky: retries exhausted or ID mismatch

Behaviour:
- Reset values: all outputs 0; lut_index=0; state IDLE. Reset mid-transaction abandons the sequence immediately; i2c_req drops the next cycle.
- States and transitions:
  - IDLE: on start, clear cfg_done/cfg_error, lut_index=0 → FETCH. start is ignored while busy.
  - FETCH: register lut_data into addr/data latches (one-cycle LUT settle). Then:
    - if lut_index>=lut_size → DONE;
    - else if address==0 → DELAY;
    - else → ISSUE.
  - ISSUE: assert i2c_req with i2c_addr/i2c_wdata from the latches → WAIT.
  - WAIT: hold i2c_req and all bus outputs stable.
    - i2c_ack: clear retry counter → NEXT.
    - i2c_nack with retry_cnt<MAX_RETRY: retry_cnt++, drop req one cycle → ISSUE.
    - i2c_nack with retry_cnt==MAX_RETRY → ERROR.
    - ack and nack in the same cycle: treated as nack.
  - DELAY: count DELAY_CYC cycles (counter 0..DELAY_CYC-1) → NEXT.
  - NEXT: lut_index++ → FETCH.
  - DONE: cfg_done=1, busy=0 → IDLE.
  - ERROR: cfg_error=1, busy=0 → IDLE.
- busy=1 in every state except IDLE.
- cfg_done and cfg_error hold until the next accepted start.
- lut_size=0: straight to DONE, no bus traffic.
- Index 0 is the chip-ID entry (see Optional Feature).
- Latency: start → first i2c_req = 3 cycles (IDLE, FETCH, ISSUE registered).
- No index wrap: the sequence stops at lut_size. lut_size up to 2^IDX_W-1 is supported.

Optional Feature:
Macro CFG_ID_CHECK_EN.
- Defined: entry 0 is issued as a read (i2c_rd=1). On i2c_ack, i2c_rdata is compared to the entry's data field.
  - Mismatch → ERROR, with no retry.
  - Match → NEXT.
  - NACK follows the normal retry rules.
- Undefined: entry 0 is skipped (no bus traffic), FETCH proceeds to index 1. i2c_rd is tied 0.

Decomposition:
- Shared package i2c_cfg_pkg: state encoding enum, DELAY_TOKEN_ADDR=0 constant, default widths.
- One natural sub-module, i2c_cfg_delay_cnt: loadable down-counter with a done flag, reused by the sensor power-up sequencer.

Test Plan:
- 4-entry LUT {ID, 301A/00D9, 0000/0000, 301A/10DC}, DELAY_CYC=50, slave always acks → two writes in order, 50-cycle gap with no i2c_req between them, cfg_done high, cfg_error low.
- NACK entry 1 twice, then ack, MAX_RETRY=3 → three requests carrying identical address/data, sequence completes with cfg_done.
- NACK entry 1 four times → cfg_error=1, cfg_done=0, busy low, no further requests.
- CFG_ID_CHECK_EN defined, i2c_rdata=16'h0554 vs entry data 16'h0554 → proceeds; rdata=16'h0555 → cfg_error after one read.
- Assert rst during WAIT of entry 2 → next cycle: i2c_req=0, lut_index=0, busy=0. A subsequent start restarts from index 0.
- lut_size=0, and start pulsed while busy → immediate cfg_done with no traffic; the mid-sequence start is ignored.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
// -----------------------------------------------------------------------------
// i2c_cfg_pkg
// Shared definitions for the I2C configuration sequencer and its helpers:
//   - default generic widths for 16-bit-address / 16-bit-data sensors
//   - DELAY_TOKEN_ADDR: register address value that marks a LUT delay entry
//   - cfg_state_t: sequencer state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package i2c_cfg_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_IDX_W     = 8;
    localparam int DEF_DELAY_W   = 20;
    localparam int DEF_MAX_RETRY = 3;

    // A LUT entry whose register address equals this value is a delay token.
    localparam int DELAY_TOKEN_ADDR = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_DELAY,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } cfg_state_t;

endpackage

// File: rtl/i2c_cfg_delay_cnt.sv
// -----------------------------------------------------------------------------
// i2c_cfg_delay_cnt
// Loadable down-counter with a terminal-count flag. Loading N and then
// enabling gives done after N enabled cycles (done is high while count==0).
// Shared with the sensor power-up sequencer.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   load      in   load load_val into the counter (has priority over en)
//   load_val  in   W  value to load
//   en        in   decrement enable; the counter stops at zero
//   done      out  count has reached zero
// -----------------------------------------------------------------------------
module i2c_cfg_delay_cnt #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_cfg_sequencer
// Walks an external {register address, register data} configuration LUT and
// issues one I2C register write per entry to the I2C master through a
// request/acknowledge handshake. Entries with an all-zero address are delay
// tokens (no bus traffic, DELAY_CYC clock wait). NACKed transfers are re-issued
// up to MAX_RETRY times before the sequence aborts with cfg_error.
//
// Optional feature, macro CFG_ID_CHECK_EN:
//   defined   - entry 0 is issued as a read; the returned data must equal the
//               entry's data field or the sequence aborts with cfg_error.
//   undefined - entry 0 is skipped without bus traffic and i2c_rd stays 0.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse; starts a sequence when idle
//   lut_index  out  IDX_W          LUT entry being processed
//   lut_data   in   ADDR_W+DATA_W  {addr, data} of lut_index (combinational)
//   lut_size   in   IDX_W          number of LUT entries
//   i2c_req    out  transaction request, held until i2c_ack / i2c_nack
//   i2c_rd     out  1 = read transaction (chip-ID check)
//   i2c_addr   out  ADDR_W  register address
//   i2c_wdata  out  DATA_W  write data
//   i2c_rdata  in   DATA_W  read data, valid with i2c_ack
//   i2c_ack    in   one-cycle completion pulse
//   i2c_nack   in   one-cycle slave NACK pulse
//   busy       out  sequence in progress
//   cfg_done   out  sticky: all entries completed
//   cfg_error  out  sticky: retries exhausted or chip-ID mismatch
// -----------------------------------------------------------------------------
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int                   ADDR_W    = DEF_ADDR_W,
    parameter int                   DATA_W    = DEF_DATA_W,
    parameter int                   IDX_W     = DEF_IDX_W,
    parameter int                   DELAY_W   = DEF_DELAY_W,
    parameter logic [DELAY_W-1:0]   DELAY_CYC = 20'd200000,
    parameter int                   MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [IDX_W-1:0]         lut_index,
    input  logic [ADDR_W+DATA_W-1:0] lut_data,
    input  logic [IDX_W-1:0]         lut_size,
    output logic                     i2c_req,
    output logic                     i2c_rd,
    output logic [ADDR_W-1:0]        i2c_addr,
    output logic [DATA_W-1:0]        i2c_wdata,
    input  logic [DATA_W-1:0]        i2c_rdata,
    input  logic                     i2c_ack,
    input  logic                     i2c_nack,
    output logic                     busy,
    output logic                     cfg_done,
    output logic                     cfg_error
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // The counter runs DELAY_CYC-1 down to 0, i.e. DELAY_CYC cycles in DELAY.
    // A DELAY_CYC of 0 degenerates to a single wait cycle.
    localparam logic [DELAY_W-1:0] DELAY_LOAD =
        (DELAY_CYC == '0) ? '0 : DELAY_CYC - DELAY_W'(1);

    cfg_state_t           state;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    data_q;
    logic [RETRY_W-1:0]   retry_cnt;

    logic [ADDR_W-1:0]    lut_addr;
    logic [DATA_W-1:0]    lut_wdata;
    logic                 dly_load;
    logic                 dly_en;
    logic                 dly_done;

    assign lut_addr  = lut_data[ADDR_W+DATA_W-1 -: ADDR_W];
    assign lut_wdata = lut_data[DATA_W-1:0];

    // The delay counter is reloaded on every fetch; only a delay token lets
    // it run, so the load is unconditional.
    assign dly_load = (state == ST_FETCH);
    assign dly_en   = (state == ST_DELAY);

    i2c_cfg_delay_cnt #(
        .W        (DELAY_W)
    ) u_delay_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (dly_load),
        .load_val (DELAY_LOAD),
        .en       (dly_en),
        .done     (dly_done)
    );

`ifndef CFG_ID_CHECK_EN
    // Read data only matters for the chip-ID check.
    logic unused_rdata;
    assign unused_rdata = ^i2c_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the address/data latches are reset along with the control
            // state; they are plain registers, not a memory array, so reset
            // costs nothing and keeps the bus outputs defined from power-up.
            state     <= ST_IDLE;
            lut_index <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            retry_cnt <= '0;
            i2c_req   <= 1'b0;
            i2c_rd    <= 1'b0;
            i2c_addr  <= '0;
            i2c_wdata <= '0;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
                        lut_index <= '0;
                        retry_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end

                // lut_index was updated one cycle ago, so lut_data has settled.
                ST_FETCH: begin
                    addr_q <= lut_addr;
                    data_q <= lut_wdata;
                    if (lut_index >= lut_size) begin
                        state <= ST_DONE;
                    end else if (lut_index == '0) begin
`ifdef CFG_ID_CHECK_EN
                        state <= ST_ISSUE;
`else
                        state <= ST_NEXT;
`endif
                    end else if (lut_addr == ADDR_W'(DELAY_TOKEN_ADDR)) begin
                        state <= ST_DELAY;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    i2c_req   <= 1'b1;
                    i2c_addr  <= addr_q;
                    i2c_wdata <= data_q;
`ifdef CFG_ID_CHECK_EN
                    i2c_rd    <= (lut_index == '0);
`else
                    i2c_rd    <= 1'b0;
`endif
                    state     <= ST_WAIT;
                end

                // NACK wins over a simultaneous ACK. The request drops for the
                // ISSUE cycle before a retry so the master sees a fresh request.
                ST_WAIT: begin
                    if (i2c_nack) begin
                        i2c_req <= 1'b0;
                        i2c_rd  <= 1'b0;
                        if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            state     <= ST_ISSUE;
                        end else begin
                            state <= ST_ERROR;
                        end
                    end else if (i2c_ack) begin
                        i2c_req   <= 1'b0;
                        i2c_rd    <= 1'b0;
                        retry_cnt <= '0;
`ifdef CFG_ID_CHECK_EN
                        // A bad chip ID is a wrong part, not a bus glitch: no retry.
                        if (i2c_rd && (i2c_rdata != data_q)) begin
                            state <= ST_ERROR;
                        end else begin
                            state <= ST_NEXT;
                        end
`else
                        state <= ST_NEXT;
`endif
                    end
                end

                ST_DELAY: begin
                    if (dly_done) begin
                        state <= ST_NEXT;
                    end
                end

                ST_NEXT: begin
                    lut_index <= lut_index + IDX_W'(1);
                    state     <= ST_FETCH;
                end

                ST_DONE: begin
                    cfg_done <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end

                ST_ERROR: begin
                    cfg_error <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_cfg_sequencer
// Bench for i2c_cfg_sequencer (DELAY_CYC=50, MAX_RETRY=3, 16/16-bit LUT).
// A transaction-level model turns the LUT and the slave's response plan into
// the ordered list of requests the DUT must issue (with the idle gap before
// each) and the final done/error flags. One monitor checks every request edge
// and every held-request cycle against that list. Works with or without
// CFG_ID_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_i2c_cfg_sequencer;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int IDX_W     = 8;
    localparam int DELAY_W   = 20;
    localparam int DELAY_CYC = 50;
    localparam int MAX_RETRY = 3;
    localparam int SEQ_LIMIT = 4000;

`ifdef CFG_ID_CHECK_EN
    localparam bit ID_MODE = 1'b1;
`else
    localparam bit ID_MODE = 1'b0;
`endif
    localparam int ID_REQS = ID_MODE ? 1 : 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rd;
        int                gap;   // idle cycles before this request, -1 = unchecked
    } txn_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [IDX_W-1:0]         lut_index;
    logic [ADDR_W+DATA_W-1:0] lut_data;
    logic [IDX_W-1:0]         lut_size;
    logic                     i2c_req;
    logic                     i2c_rd;
    logic [ADDR_W-1:0]        i2c_addr;
    logic [DATA_W-1:0]        i2c_wdata;
    logic [DATA_W-1:0]        i2c_rdata;
    logic                     i2c_ack;
    logic                     i2c_nack;
    logic                     busy;
    logic                     cfg_done;
    logic                     cfg_error;

    logic [ADDR_W+DATA_W-1:0] lut_mem [256];
    int                       plan_kind [256];   // 0 ack, 1 nack, 2 ack+nack
    int                       slave_ord;
    int                       max_lat;
    logic [DATA_W-1:0]        id_rdata;

    txn_t                     exp_q [$];
    bit                       exp_done;
    bit                       exp_err;
    bit                       chk_en;
    int                       req_seen;
    int                       last_gap;
    time                      start_time;
    time                      first_req_time;

    int                       n_checks = 0;
    int                       n_fail   = 0;

    assign lut_data = lut_mem[lut_index];

    initial forever #5 clk = ~clk;

    i2c_cfg_sequencer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .DELAY_W   (DELAY_W),
        .DELAY_CYC (DELAY_W'(DELAY_CYC)),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lut_index (lut_index),
        .lut_data  (lut_data),
        .lut_size  (lut_size),
        .i2c_req   (i2c_req),
        .i2c_rd    (i2c_rd),
        .i2c_addr  (i2c_addr),
        .i2c_wdata (i2c_wdata),
        .i2c_rdata (i2c_rdata),
        .i2c_ack   (i2c_ack),
        .i2c_nack  (i2c_nack),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: which requests, in which order, with which
    // idle gap, and how the sequence ends.
    task automatic build_model();
        int                ord;
        int                pend_gap;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit                is_id;
        bit                acked;
        txn_t              t;
        ord      = 0;
        pend_gap = -1;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int i = 0; i < int'(lut_size); i++) begin
            a     = lut_mem[i][ADDR_W+DATA_W-1 -: ADDR_W];
            d     = lut_mem[i][DATA_W-1:0];
            is_id = (i == 0);
            if (is_id && !ID_MODE) continue;
            if (!is_id && a == '0) begin
                // token: NEXT + FETCH + DELAY_CYC wait cycles
                if (pend_gap >= 0) pend_gap += DELAY_CYC + 2;
                continue;
            end
            acked = 1'b0;
            for (int attempt = 0; attempt <= MAX_RETRY && !acked; attempt++) begin
                t.addr = a;
                t.data = d;
                t.rd   = is_id;
                t.gap  = (attempt == 0) ? pend_gap : 1;
                exp_q.push_back(t);
                if (plan_kind[ord] != 0) begin
                    if (attempt == MAX_RETRY) begin
                        exp_err = 1'b1;
                        return;
                    end
                end else begin
                    if (is_id && id_rdata != d) begin
                        exp_err = 1'b1;
                        return;
                    end
                    acked = 1'b1;
                end
                ord++;
            end
            pend_gap = 3;   // NEXT, FETCH, ISSUE between consecutive entries
        end
        exp_done = 1'b1;
    endtask

    // Slave model: answers each request after 0..max_lat cycles following
    // plan_kind, one plan entry per request.
    initial begin
        int lat;
        bit sent;
        lat = -1;
        sent = 1'b0;
        i2c_ack = 1'b0;
        i2c_nack = 1'b0;
        i2c_rdata = '0;
        forever begin
            @(negedge clk);
            i2c_ack  = 1'b0;
            i2c_nack = 1'b0;
            if (!i2c_req) begin
                sent = 1'b0;
                lat  = -1;
            end else if (!sent) begin
                if (lat < 0) lat = $urandom_range(0, max_lat);
                if (lat == 0) begin
                    case (plan_kind[slave_ord])
                        0:       i2c_ack = 1'b1;
                        1:       i2c_nack = 1'b1;
                        default: begin i2c_ack = 1'b1; i2c_nack = 1'b1; end
                    endcase
                    i2c_rdata = i2c_rd ? id_rdata : DATA_W'($urandom);
                    slave_ord++;
                    sent = 1'b1;
                    lat  = -1;
                end else begin
                    lat--;
                end
            end
        end
    end

    // Monitor: every request edge and every held cycle against the model.
    initial begin
        bit                       prev_req;
        int                       low_cnt;
        txn_t                     e;
        logic [ADDR_W+DATA_W:0]   hold;
        prev_req = 1'b0;
        low_cnt  = 0;
        hold     = '0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (i2c_req && !prev_req) begin
                    req_seen++;
                    if (req_seen == 1) first_req_time = $time;
                    check("req_expected", 64'(exp_q.size() > 0), 64'd1);
                    hold = {i2c_addr, i2c_wdata, i2c_rd};
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("req_fields", 64'(hold), 64'({e.addr, e.data, e.rd}));
                        if (e.gap >= 0) check("req_gap", 64'(low_cnt), 64'(e.gap));
                    end
                    last_gap = low_cnt;
                end else if (i2c_req) begin
                    check("req_stable", 64'({i2c_addr, i2c_wdata, i2c_rd}), 64'(hold));
                end
                if (i2c_req) check("busy_with_req", 64'(busy), 64'd1);
                if (busy) check("index_in_range", 64'(lut_index <= lut_size), 64'd1);
            end
            if (i2c_req) low_cnt = 0;
            else         low_cnt++;
            prev_req = i2c_req;
        end
    end

    task automatic clear_plan();
        for (int i = 0; i < 256; i++) plan_kind[i] = 0;
    endtask

    task automatic load_basic(input logic [31:0] entry2);
        for (int i = 0; i < 256; i++) lut_mem[i] = '0;
        lut_mem[0] = 32'h3000_0554;
        lut_mem[1] = 32'h301A_00D9;
        lut_mem[2] = entry2;
        lut_mem[3] = 32'h301A_10DC;
        lut_size   = 8'd4;
        id_rdata   = 16'h0554;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_time = $time;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_seq(input bit mid_start, output int cycles);
        slave_ord = 0;
        req_seen  = 0;
        build_model();
        chk_en = 1'b1;
        pulse_start();
        check("start_accept", 64'({busy, cfg_done, cfg_error}), 64'b100);
        cycles = 0;
        while (busy && cycles < SEQ_LIMIT) begin
            @(negedge clk);
            cycles++;
            if (mid_start && cycles == 7 && busy) start = 1'b1;
            else                                  start = 1'b0;
        end
        start = 1'b0;
        if (busy) check("seq_finished", 64'(busy), 64'd0);
        check("cfg_done", 64'(cfg_done), 64'(exp_done));
        check("cfg_error", 64'(cfg_error), 64'(exp_err));
        check("txn_remaining", 64'(exp_q.size()), 64'd0);
        check("req_idle", 64'(i2c_req), 64'd0);
    endtask

    initial begin
        int cycles;
        int seen;
        rst = 1'b1;
        start = 1'b0;
        chk_en = 1'b0;
        max_lat = 2;
        slave_ord = 0;
        req_seen = 0;
        last_gap = 0;
        first_req_time = 0;
        start_time = 0;
        id_rdata = 16'h0554;
        lut_size = '0;
        clear_plan();
        for (int i = 0; i < 256; i++) lut_mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_state",
              64'({i2c_req, i2c_rd, busy, cfg_done, cfg_error, lut_index, i2c_addr, i2c_wdata}),
              64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two writes with a delay token between them; a stray start while busy
        load_basic(32'h0000_0000);
        build_model();
        check("model_txn_count", 64'(exp_q.size()), 64'(2 + ID_REQS));
        check("model_token_gap", 64'(exp_q[exp_q.size()-1].gap), 64'd55);
        run_seq(1'b1, cycles);
        check("basic_req_count", 64'(req_seen), 64'(2 + ID_REQS));
        check("basic_token_gap", 64'(last_gap), 64'd55);
        check("basic_flags", 64'({cfg_done, cfg_error, busy}), 64'b100);
`ifdef CFG_ID_CHECK_EN
        check("start_to_req_latency", 64'((first_req_time - start_time) / 10), 64'd3);
`endif
        repeat (10) @(negedge clk);
        check("done_sticky", 64'({cfg_done, cfg_error, busy}), 64'b100);

        // Entry 1 NACKed twice (second time with a simultaneous ACK), then ACKed
        clear_plan();
        plan_kind[ID_REQS + 0] = 1;
        plan_kind[ID_REQS + 1] = 2;
        run_seq(1'b0, cycles);
        check("retry_req_count", 64'(req_seen), 64'(4 + ID_REQS));
        check("retry_flags", 64'({cfg_done, cfg_error}), 64'b10);

        // Entry 1 NACKed four times: retries exhausted
        clear_plan();
        for (int i = 0; i < 4; i++) plan_kind[ID_REQS + i] = 1;
        run_seq(1'b0, cycles);
        check("exhaust_req_count", 64'(req_seen), 64'(4 + ID_REQS));
        check("exhaust_flags", 64'({cfg_done, cfg_error, busy}), 64'b010);
        seen = req_seen;
        repeat (20) @(negedge clk);
        check("exhaust_no_more_req", 64'(req_seen), 64'(seen));

        // Empty LUT
        clear_plan();
        lut_size = 8'd0;
        run_seq(1'b0, cycles);
        check("empty_lut_cycles", 64'(cycles), 64'd2);
        check("empty_lut_reqs", 64'(req_seen), 64'd0);
        check("empty_lut_flags", 64'({cfg_done, cfg_error}), 64'b10);

`ifdef CFG_ID_CHECK_EN
        // Chip-ID match and mismatch
        load_basic(32'h0000_0000);
        id_rdata = 16'h0554;
        run_seq(1'b0, cycles);
        check("id_match_flags", 64'({cfg_done, cfg_error}), 64'b10);
        id_rdata = 16'h0555;
        run_seq(1'b0, cycles);
        check("id_mismatch_flags", 64'({cfg_done, cfg_error}), 64'b01);
        check("id_mismatch_reqs", 64'(req_seen), 64'd1);
        id_rdata = 16'h0554;
`endif

        // Reset while entry 2 is waiting for its response, then restart
        load_basic(32'h3020_0001);
        clear_plan();
        max_lat = 3;
        slave_ord = 0;
        req_seen = 0;
        build_model();
        chk_en = 1'b1;
        pulse_start();
        cycles = 0;
        while (!(i2c_req && lut_index == 8'd2) && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        check("reached_entry2_wait", 64'(i2c_req && lut_index == 8'd2), 64'd1);
        chk_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_wait", 64'({i2c_req, lut_index, busy}), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        run_seq(1'b0, cycles);
        check("restart_req_count", 64'(req_seen), 64'(3 + ID_REQS));

        // Randomized LUTs, response plans and slave latencies
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < 256; i++) lut_mem[i] = '0;
            lut_size = IDX_W'($urandom_range(0, 12));
            lut_mem[0] = 32'h3000_0554;
            for (int i = 1; i < 13; i++) begin
                if ($urandom_range(0, 3) == 0)
                    lut_mem[i] = {16'h0000, 16'($urandom)};
                else
                    lut_mem[i] = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom)};
            end
            id_rdata = ($urandom_range(0, 5) == 0) ? 16'h0555 : 16'h0554;
            for (int i = 0; i < 256; i++) begin
                int r;
                r = $urandom_range(0, 9);
                plan_kind[i] = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
            end
            max_lat = $urandom_range(0, 3);
            run_seq($urandom_range(0, 3) == 0, cycles);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
